// File: rtl/assert_event_monitor_if.sv
// Sample bus feeding the event monitor: one qualified a/b/c triple per cycle.
interface assert_event_monitor_if #(
  parameter int DATA_W = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] c;

  modport master (output in_valid, a, b, c);
  modport slave  (input  in_valid, a, b, c);
endinterface

// File: rtl/assert_event_monitor.sv
// Hardware checker for "(a > THRESH_AB | b > THRESH_AB) implies c <= LIMIT_C".
// Keeps saturating statistics, a sticky fail flag and a first-failure
// capture. Optionally halts on the first failure so the statistics freeze
// for readout.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | disabled; no samples accepted, in-flight sample still retires
// RUN   | accepting one sample per cycle
// HALT  | frozen after first fail (STOP_ON_FAIL); leave via clr+en or en=0
module assert_event_monitor #(
  parameter int DATA_W       = 4,
  parameter int CNT_W        = 16,
  parameter int THRESH_AB    = 5,
  parameter int LIMIT_C      = 9,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  assert_event_monitor_if.slave smp,
  output logic                  pass_pulse,
  output logic                  fail_pulse,
  output logic [CNT_W-1:0]      sample_cnt,
  output logic [CNT_W-1:0]      attempt_cnt,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic [CNT_W-1:0]      vacuous_cnt,
  output logic                  fail_sticky,
  output logic [DATA_W-1:0]     first_fail_a,
  output logic [DATA_W-1:0]     first_fail_b,
  output logic [DATA_W-1:0]     first_fail_c,
  output logic [CNT_W-1:0]      first_fail_idx,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [DATA_W-1:0] THR = DATA_W'(THRESH_AB);
  localparam logic [DATA_W-1:0] LIM = DATA_W'(LIMIT_C);

  state_t            state_q;
  state_t            state_d;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [DATA_W-1:0] s1_c;

  logic              accept;
  logic              eval;
  logic              ante;
  logic              cons;
  logic              is_pass;
  logic              is_fail;
  logic              is_vac;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign accept  = smp.in_valid & (state_q == ST_RUN) & ~clr;
  // clr wins over a retiring sample: it is dropped, not counted.
  assign eval    = s1_valid & ~clr;
  assign ante    = (s1_a > THR) | (s1_b > THR);
  assign cons    = (s1_c <= LIM);
  assign is_pass = eval & ante & cons;
  assign is_fail = eval & ante & ~cons;
  assign is_vac  = eval & ~ante;
  assign state   = state_q;

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Mode next-state; en=0 dominates, a fail halts only when configured to.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN: begin
        if (!en)                          state_d = ST_IDLE;
        else if (STOP_ON_FAIL && is_fail) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (!en)      state_d = ST_IDLE;
        else if (clr) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // S1: capture the accepted sample; clr flushes the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a <= smp.a;
        s1_b <= smp.b;
        s1_c <= smp.c;
      end
    end
  end

  // S2: one-cycle result pulses for the sample retiring this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
    end else begin
      pass_pulse <= is_pass;
      fail_pulse <= is_fail;
    end
  end

  // S2: saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt  <= '0;
      attempt_cnt <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      vacuous_cnt <= '0;
    end else if (clr) begin
      sample_cnt  <= '0;
      attempt_cnt <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      vacuous_cnt <= '0;
    end else if (eval) begin
      sample_cnt <= sat_inc(sample_cnt);
      if (is_vac)  vacuous_cnt <= sat_inc(vacuous_cnt);
      if (ante)    attempt_cnt <= sat_inc(attempt_cnt);
      if (is_pass) pass_cnt    <= sat_inc(pass_cnt);
      if (is_fail) fail_cnt    <= sat_inc(fail_cnt);
    end
  end

  // S2: sticky flag and first-failure capture (index is pre-increment count).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_sticky    <= 1'b0;
      first_fail_a   <= '0;
      first_fail_b   <= '0;
      first_fail_c   <= '0;
      first_fail_idx <= '0;
    end else if (clr) begin
      fail_sticky    <= 1'b0;
      first_fail_a   <= '0;
      first_fail_b   <= '0;
      first_fail_c   <= '0;
      first_fail_idx <= '0;
    end else if (is_fail) begin
      fail_sticky <= 1'b1;
      if (!fail_sticky) begin
        first_fail_a   <= s1_a;
        first_fail_b   <= s1_b;
        first_fail_c   <= s1_c;
        first_fail_idx <= sample_cnt;
      end
    end
  end

endmodule

// File: tb/tb_assert_event_monitor.sv
// Directed bench: default monitor (d0), halt-on-fail monitor (d1) and a
// 3-bit-counter monitor (d2) sharing one clock and reset.
module tb_assert_event_monitor;

  logic clk = 1'b0;
  logic rst_n;
  logic en0, en1, en2;
  logic clr0, clr1, clr2;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  assert_event_monitor_if #(.DATA_W(4)) if0 ();
  assert_event_monitor_if #(.DATA_W(4)) if1 ();
  assert_event_monitor_if #(.DATA_W(4)) if2 ();

  logic        d0_pp, d0_fp, d0_st;
  logic [15:0] d0_smp, d0_att, d0_pas, d0_fal, d0_vac, d0_idx;
  logic [3:0]  d0_fa, d0_fb, d0_fc;
  logic [1:0]  d0_state;

  logic        d1_pp, d1_fp, d1_st;
  logic [15:0] d1_smp, d1_att, d1_pas, d1_fal, d1_vac, d1_idx;
  logic [3:0]  d1_fa, d1_fb, d1_fc;
  logic [1:0]  d1_state;

  logic        d2_pp, d2_fp, d2_st;
  logic [2:0]  d2_smp, d2_att, d2_pas, d2_fal, d2_vac, d2_idx;
  logic [3:0]  d2_fa, d2_fb, d2_fc;
  logic [1:0]  d2_state;

  assert_event_monitor u_d0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .clr(clr0), .smp(if0.slave),
    .pass_pulse(d0_pp), .fail_pulse(d0_fp),
    .sample_cnt(d0_smp), .attempt_cnt(d0_att), .pass_cnt(d0_pas),
    .fail_cnt(d0_fal), .vacuous_cnt(d0_vac), .fail_sticky(d0_st),
    .first_fail_a(d0_fa), .first_fail_b(d0_fb), .first_fail_c(d0_fc),
    .first_fail_idx(d0_idx), .state(d0_state)
  );

  assert_event_monitor #(.STOP_ON_FAIL(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .clr(clr1), .smp(if1.slave),
    .pass_pulse(d1_pp), .fail_pulse(d1_fp),
    .sample_cnt(d1_smp), .attempt_cnt(d1_att), .pass_cnt(d1_pas),
    .fail_cnt(d1_fal), .vacuous_cnt(d1_vac), .fail_sticky(d1_st),
    .first_fail_a(d1_fa), .first_fail_b(d1_fb), .first_fail_c(d1_fc),
    .first_fail_idx(d1_idx), .state(d1_state)
  );

  assert_event_monitor #(.CNT_W(3)) u_d2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .clr(clr2), .smp(if2.slave),
    .pass_pulse(d2_pp), .fail_pulse(d2_fp),
    .sample_cnt(d2_smp), .attempt_cnt(d2_att), .pass_cnt(d2_pas),
    .fail_cnt(d2_fal), .vacuous_cnt(d2_vac), .fail_sticky(d2_st),
    .first_fail_a(d2_fa), .first_fail_b(d2_fb), .first_fail_c(d2_fc),
    .first_fail_idx(d2_idx), .state(d2_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    if0.in_valid = v; if0.a = a; if0.b = b; if0.c = c;
    step();
  endtask

  task automatic send1(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    if1.in_valid = v; if1.a = a; if1.b = b; if1.c = c;
    step();
  endtask

  task automatic send2(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    if2.in_valid = v; if2.a = a; if2.b = b; if2.c = c;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.c = '0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.c = '0;
    if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.c = '0;
    #2;
    chk("rst_state",  32'(d0_state), 0);
    chk("rst_sample", 32'(d0_smp), 0);
    chk("rst_sticky", 32'(d0_st), 0);
    #10;
    rst_n = 1'b1;
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
    step();
    chk("run_state", 32'(d0_state), 1);

    // basic stream: pass, vacuous, pass
    send0(1'b1, 4'd7, 4'd0, 4'd3);
    send0(1'b1, 4'd0, 4'd0, 4'd12);
    chk("s1_pass_pulse", 32'(d0_pp), 1);
    send0(1'b1, 4'd2, 4'd9, 4'd9);
    chk("s2_vac_pp", 32'(d0_pp), 0);
    chk("s2_vac_fp", 32'(d0_fp), 0);
    send0(1'b0, 4'd0, 4'd0, 4'd0);
    chk("s3_pass_pulse", 32'(d0_pp), 1);
    chk("basic_sample",  32'(d0_smp), 3);
    chk("basic_attempt", 32'(d0_att), 2);
    chk("basic_pass",    32'(d0_pas), 2);
    chk("basic_vac",     32'(d0_vac), 1);
    chk("basic_sticky",  32'(d0_st), 0);

    // first fail at index 4, later fail leaves capture alone
    send0(1'b1, 4'd1, 4'd1, 4'd1);
    send0(1'b1, 4'd6, 4'd0, 4'd10);
    chk("pre_fail_fp", 32'(d0_fp), 0);
    send0(1'b0, 4'd0, 4'd0, 4'd0);
    chk("fail_pulse",  32'(d0_fp), 1);
    chk("fail_cnt1",   32'(d0_fal), 1);
    chk("fail_sticky", 32'(d0_st), 1);
    chk("ff_a",        32'(d0_fa), 6);
    chk("ff_b",        32'(d0_fb), 0);
    chk("ff_c",        32'(d0_fc), 10);
    chk("ff_idx",      32'(d0_idx), 4);
    chk("fail_sample", 32'(d0_smp), 5);
    send0(1'b1, 4'd0, 4'd8, 4'd15);
    send0(1'b0, 4'd0, 4'd0, 4'd0);
    chk("fail_cnt2",   32'(d0_fal), 2);
    chk("ff_b_hold",   32'(d0_fb), 0);
    chk("ff_c_hold",   32'(d0_fc), 10);
    chk("ff_idx_hold", 32'(d0_idx), 4);

    // clr then exact compare boundaries
    clr0 = 1'b1;
    send0(1'b0, 4'd0, 4'd0, 4'd0);
    clr0 = 1'b0;
    chk("clr_sample", 32'(d0_smp), 0);
    chk("clr_fail",   32'(d0_fal), 0);
    chk("clr_sticky", 32'(d0_st), 0);
    chk("clr_ff_c",   32'(d0_fc), 0);
    chk("clr_state",  32'(d0_state), 1);
    send0(1'b1, 4'd5, 4'd5, 4'd15);
    send0(1'b1, 4'd6, 4'd0, 4'd9);
    chk("bnd_vac_pp", 32'(d0_pp), 0);
    chk("bnd_vac_fp", 32'(d0_fp), 0);
    send0(1'b1, 4'd0, 4'd6, 4'd10);
    chk("bnd_pass_pp", 32'(d0_pp), 1);
    send0(1'b0, 4'd0, 4'd0, 4'd0);
    chk("bnd_fail_fp", 32'(d0_fp), 1);
    chk("bnd_vac",     32'(d0_vac), 1);
    chk("bnd_pass",    32'(d0_pas), 1);
    chk("bnd_fail",    32'(d0_fal), 1);
    chk("bnd_attempt", 32'(d0_att), 2);

    // clr coinciding with a failing sample's retirement
    clr0 = 1'b1;
    send0(1'b0, 4'd0, 4'd0, 4'd0);
    clr0 = 1'b0;
    send0(1'b1, 4'd7, 4'd0, 4'd12);
    if0.in_valid = 1'b0;
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    chk("clrret_fp",     32'(d0_fp), 0);
    chk("clrret_fail",   32'(d0_fal), 0);
    chk("clrret_sticky", 32'(d0_st), 0);
    step();
    chk("clrret_sample", 32'(d0_smp), 0);

    // en falling with a sample in S1: still counted
    send0(1'b1, 4'd6, 4'd0, 4'd0);
    if0.in_valid = 1'b0;
    en0 = 1'b0;
    step();
    chk("enoff_state",  32'(d0_state), 0);
    chk("enoff_pp",     32'(d0_pp), 1);
    chk("enoff_sample", 32'(d0_smp), 1);
    send0(1'b1, 4'd6, 4'd0, 4'd0);
    send0(1'b0, 4'd0, 4'd0, 4'd0);
    chk("idle_noaccept", 32'(d0_smp), 1);
    en0 = 1'b1;
    step();

    // halt on first fail
    send1(1'b1, 4'd1, 4'd9, 4'd14);
    send1(1'b1, 4'd7, 4'd7, 4'd0);
    chk("halt_state", 32'(d1_state), 2);
    chk("halt_fp",    32'(d1_fp), 1);
    send1(1'b1, 4'd8, 4'd8, 4'd1);
    chk("halt_pp2",    32'(d1_pp), 1);
    chk("halt_state2", 32'(d1_state), 2);
    send1(1'b0, 4'd0, 4'd0, 4'd0);
    chk("halt_pp3",    32'(d1_pp), 0);
    chk("halt_sample", 32'(d1_smp), 2);
    chk("halt_pass",   32'(d1_pas), 1);
    chk("halt_fail",   32'(d1_fal), 1);
    clr1 = 1'b1;
    send1(1'b0, 4'd0, 4'd0, 4'd0);
    clr1 = 1'b0;
    chk("hclr_state",  32'(d1_state), 1);
    chk("hclr_sample", 32'(d1_smp), 0);
    chk("hclr_pass",   32'(d1_pas), 0);
    chk("hclr_fail",   32'(d1_fal), 0);
    chk("hclr_sticky", 32'(d1_st), 0);

    // saturation with 3-bit counters
    for (int i = 0; i < 9; i++) send2(1'b1, 4'd6, 4'd0, 4'd0);
    send2(1'b0, 4'd0, 4'd0, 4'd0);
    chk("sat_pass",    32'(d2_pas), 7);
    chk("sat_sample",  32'(d2_smp), 7);
    chk("sat_attempt", 32'(d2_att), 7);

    // asynchronous reset mid-stream
    send0(1'b1, 4'd7, 4'd0, 4'd3);
    if0.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state",  32'(d0_state), 0);
    chk("arst_sample", 32'(d0_smp), 0);
    chk("arst_pp",     32'(d0_pp), 0);
    chk("arst_state1", 32'(d1_state), 0);
    #2;
    rst_n = 1'b1;
    step();
    step();
    chk("arst_discard", 32'(d0_smp), 0);
    chk("arst_pp2",     32'(d0_pp), 0);
    chk("arst_run",     32'(d0_state), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
